// File: rtl/rv32_pkg.sv
// Shared constants, state encoding and small helpers for the RV32 memory stage.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // True when funct3 is legal for the access type and the address is naturally aligned.
  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    if ((f3[1:0] == 2'b01) && off[0])
      ok = 1'b0;
    if ((f3[1:0] == 2'b10) && (off != 2'b00))
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'd0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'd0, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_mem_access_stage.sv
// MEM stage: runs loads/stores over a req/gnt/rvalid data bus, stalling the pipe meanwhile.
module rv32_mem_access_stage
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] code_in,
  output logic [31:0] data_res_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] data_res_q, data_res_d;
  logic        bus_err_q, bus_err_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic        is_load, is_store, mem_op, issue, bad;
  logic [31:0] req_addr, req_wdata, load_result;
  logic [3:0]  req_be;
  logic        unused_code_bits;

  assign opcode           = code_in[6:0];
  assign funct3           = code_in[14:12];
  assign offset           = alu_res_in[1:0];
  assign unused_code_bits = ^{code_in[31:15], code_in[11:7]};
  assign is_load          = (opcode == OPC_LOAD);
  assign is_store         = (opcode == OPC_STORE);
  assign mem_op           = is_load | is_store;
  assign issue            = (state_q == MEM_IDLE) & mem_op & access_ok(is_load, funct3, offset);
  assign bad              = (state_q == MEM_IDLE) & mem_op & ~access_ok(is_load, funct3, offset);
  assign req_addr         = {alu_res_in[31:2], 2'b00};
  assign req_be           = byte_enables(funct3, offset);
  assign req_wdata        = store_lanes(funct3, store_data_in);
  assign data_res_out     = data_res_q;
  assign bus_err_out      = bus_err_q;

  rv32_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_result)
  );

  // Next-state logic: issue, wait for grant, wait for data, one release cycle, with timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    data_res_d = data_res_q;
    bus_err_d  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (issue) begin
          addr_d  = req_addr;
          off_d   = offset;
          be_d    = req_be;
          wdata_d = req_wdata;
          we_d    = is_store;
          f3_d    = funct3;
          cnt_d   = '0;
          if (dmem_gnt)
            state_d = is_store ? MEM_DONE : MEM_WAIT;
          else
            state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? MEM_DONE : MEM_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = MEM_DONE;
          bus_err_d = 1'b1;
          if (!we_q)
            data_res_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid) begin
          data_res_d = load_result;
          state_d    = MEM_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = MEM_DONE;
          bus_err_d  = 1'b1;
          data_res_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // State, latched request and registered results, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      data_res_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      data_res_q <= data_res_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Bus and pipeline outputs: live from the inputs in IDLE, from latched regs afterwards.
  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = addr_q;
    dmem_be      = be_q;
    dmem_wdata   = wdata_q;
    stall_out    = 1'b0;
    misalign_out = 1'b0;
    if (rst_n) begin
      case (state_q)
        MEM_IDLE: begin
          dmem_req     = issue;
          dmem_we      = issue & is_store;
          stall_out    = issue;
          misalign_out = bad;
          if (issue) begin
            dmem_addr  = req_addr;
            dmem_be    = req_be;
            dmem_wdata = req_wdata;
          end
        end
        MEM_REQ: begin
          dmem_req  = 1'b1;
          dmem_we   = we_q;
          stall_out = 1'b1;
        end
        MEM_WAIT: stall_out = 1'b1;
        default:  stall_out = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_access_stage.sv
// Scoreboard bench for rv32_mem_access_stage: the driver queues expected bus requests,
// completions and misalign events; a negedge monitor pops and compares them.
module tb_rv32_mem_access_stage;

  localparam logic [6:0]  OP_L = 7'b0000011;
  localparam logic [6:0]  OP_S = 7'b0100011;
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        bus_err;
    int          stalls;
  } cpl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_res_in, store_data_in, code_in;
  logic [31:0] data_res_out;
  logic        stall_out, misalign_out, bus_err_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  req_t        req_q[$];
  cpl_t        cpl_q[$];
  logic [31:0] mis_q[$];
  logic [31:0] exp_data;

  req_t held;
  logic prev_req  = 1'b0;
  int   stall_run = 0;

  rv32_mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_res_in    (alu_res_in),
    .store_data_in (store_data_in),
    .code_in       (code_in),
    .data_res_out  (data_res_out),
    .stall_out     (stall_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic we);
    req_t r;
    r.addr = a; r.be = be; r.wdata = wd; r.we = we;
    req_q.push_back(r);
  endtask

  task automatic expect_cpl(input logic [31:0] d, input logic be, input int st);
    cpl_t c;
    c.data = d; c.bus_err = be; c.stalls = st;
    cpl_q.push_back(c);
    exp_data = d;
  endtask

  // Drive one instruction and answer the bus at fixed cycle offsets until the stage releases it.
  task automatic applyStimulus(input logic [31:0] code, input logic [31:0] addr,
                               input logic [31:0] sdata, input int gnt_at, input int rv_at,
                               input logic [31:0] rdata, input bit rv_in_gnt);
    int  c;
    bit  done;
    c = 0;
    done = 0;
    code_in = code;
    alu_res_in = addr;
    store_data_in = sdata;
    while (!done) begin
      dmem_gnt    = (c == gnt_at);
      dmem_rvalid = (c == rv_at) || (rv_in_gnt && (c == gnt_at));
      dmem_rdata  = (c == rv_at) ? rdata : 32'hBAD0BAD0;
      @(negedge clk);
      if (!stall_out)
        done = 1;
      @(posedge clk);
      #1;
      c++;
      if (!done && c >= 40) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL stim_budget: stage still stalled after %0d cycles, expected release", c);
        done = 1;
      end
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // Monitor: compares requests, completions and misalign pulses against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 1'b0;
      stall_run = 0;
    end else begin
      if (dmem_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL unexpected_req: got req at addr 0x%08h, expected no request", dmem_addr);
            held.addr = dmem_addr; held.be = dmem_be; held.wdata = dmem_wdata; held.we = dmem_we;
          end else begin
            held = req_q.pop_front();
          end
          checkOutput("req_addr", dmem_addr, held.addr);
          checkOutput("req_be", 32'(dmem_be), 32'(held.be));
          checkOutput("req_we", 32'(dmem_we), 32'(held.we));
          if (held.we)
            checkOutput("req_wdata", dmem_wdata, held.wdata);
        end else begin
          checkOutput("req_hold_addr", dmem_addr, held.addr);
          checkOutput("req_hold_be", 32'(dmem_be), 32'(held.be));
          if (held.we)
            checkOutput("req_hold_wdata", dmem_wdata, held.wdata);
        end
      end
      prev_req = dmem_req;

      if (misalign_out) begin
        if (mis_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_misalign: got pulse, expected none");
        end else begin
          checkOutput("mis_data_res", data_res_out, mis_q.pop_front());
          checkOutput("mis_stall", 32'(stall_out), 32'd0);
        end
      end

      if (stall_out) begin
        stall_run++;
      end else if (stall_run > 0) begin
        if (cpl_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_cpl: got release after %0d stalls, expected none", stall_run);
        end else begin
          cpl_t e;
          e = cpl_q.pop_front();
          checkOutput("cpl_data_res", data_res_out, e.data);
          checkOutput("cpl_bus_err", 32'(bus_err_out), 32'(e.bus_err));
          checkOutput("cpl_stalls", stall_run, e.stalls);
        end
        stall_run = 0;
      end else if (bus_err_out) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL stray_bus_err: got 1 outside a release cycle, expected 0");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    code_in = NOP;
    alu_res_in = '0;
    store_data_in = '0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    exp_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_data_res", data_res_out, 32'd0);
    checkOutput("rst_stall", 32'(stall_out), 32'd0);
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_out), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err_out), 32'd0);
    @(posedge clk); #1;

    $display("[TB] word load, rvalid two cycles after grant");
    expect_req(32'h100, 4'hF, 32'h0, 1'b0);
    expect_cpl(32'hDEADBEEF, 1'b0, 3);
    applyStimulus(mk(OP_L, 3'b010), 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 0);

    $display("[TB] byte/half loads with extension");
    expect_req(32'h100, 4'b1000, 32'h0, 1'b0);
    expect_cpl(32'hFFFFFF80, 1'b0, 2);
    applyStimulus(mk(OP_L, 3'b000), 32'h103, 32'h0, 0, 1, 32'h80123456, 0);
    expect_req(32'h100, 4'b1000, 32'h0, 1'b0);
    expect_cpl(32'h00000080, 1'b0, 2);
    applyStimulus(mk(OP_L, 3'b100), 32'h103, 32'h0, 0, 1, 32'h80123456, 0);
    expect_req(32'h100, 4'b1100, 32'h0, 1'b0);
    expect_cpl(32'h0000BEEF, 1'b0, 2);
    applyStimulus(mk(OP_L, 3'b101), 32'h102, 32'h0, 0, 1, 32'hBEEF0000, 0);
    expect_req(32'h100, 4'b1100, 32'h0, 1'b0);
    expect_cpl(32'hFFFF8001, 1'b0, 2);
    applyStimulus(mk(OP_L, 3'b001), 32'h102, 32'h0, 0, 1, 32'h80010000, 0);

    $display("[TB] stores, one with grant delayed three cycles");
    expect_req(32'h200, 4'b0010, 32'hABABABAB, 1'b1);
    expect_cpl(exp_data, 1'b0, 4);
    applyStimulus(mk(OP_S, 3'b000), 32'h201, 32'h000000AB, 3, -1, 32'h0, 0);
    expect_req(32'h204, 4'b1100, 32'hCDEFCDEF, 1'b1);
    expect_cpl(exp_data, 1'b0, 1);
    applyStimulus(mk(OP_S, 3'b001), 32'h206, 32'h1234CDEF, 0, -1, 32'h0, 0);
    expect_req(32'h208, 4'hF, 32'hCAFEF00D, 1'b1);
    expect_cpl(exp_data, 1'b0, 2);
    applyStimulus(mk(OP_S, 3'b010), 32'h208, 32'hCAFEF00D, 1, -1, 32'h0, 0);

    $display("[TB] misaligned, illegal funct3 and non-memory ops");
    mis_q.push_back(exp_data);
    applyStimulus(mk(OP_L, 3'b010), 32'h102, 32'h0, -1, -1, 32'h0, 0);
    mis_q.push_back(exp_data);
    applyStimulus(mk(OP_S, 3'b001), 32'h105, 32'h1111, -1, -1, 32'h0, 0);
    mis_q.push_back(exp_data);
    applyStimulus(mk(OP_L, 3'b011), 32'h100, 32'h0, -1, -1, 32'h0, 0);
    mis_q.push_back(exp_data);
    applyStimulus(mk(OP_S, 3'b100), 32'h100, 32'h0, -1, -1, 32'h0, 0);
    applyStimulus(NOP, 32'h100, 32'h0, -1, -1, 32'h0, 0);

    $display("[TB] timeouts in WAIT and in REQ");
    expect_req(32'h300, 4'hF, 32'h0, 1'b0);
    expect_cpl(32'h0, 1'b1, 5);
    applyStimulus(mk(OP_L, 3'b010), 32'h300, 32'h0, 0, -1, 32'h0, 0);
    expect_req(32'h400, 4'hF, 32'h77778888, 1'b1);
    expect_cpl(exp_data, 1'b1, 5);
    applyStimulus(mk(OP_S, 3'b010), 32'h400, 32'h77778888, -1, -1, 32'h0, 0);

    $display("[TB] rvalid in the grant cycle is ignored");
    expect_req(32'h700, 4'hF, 32'h0, 1'b0);
    expect_cpl(32'h13572468, 1'b0, 3);
    applyStimulus(mk(OP_L, 3'b010), 32'h700, 32'h0, 0, 2, 32'h13572468, 1);

    $display("[TB] reset while waiting for load data");
    expect_req(32'h500, 4'hF, 32'h0, 1'b0);
    code_in = mk(OP_L, 3'b010);
    alu_res_in = 32'h500;
    store_data_in = 32'h0;
    dmem_gnt = 1'b1;
    @(posedge clk); #1 dmem_gnt = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    code_in = NOP;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11111111;
    @(negedge clk);
    checkOutput("post_rst_data_res", data_res_out, 32'd0);
    checkOutput("post_rst_stall", 32'(stall_out), 32'd0);
    checkOutput("post_rst_req", 32'(dmem_req), 32'd0);
    checkOutput("post_rst_bus_err", 32'(bus_err_out), 32'd0);
    @(posedge clk); #1 dmem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late_rvalid_data_res", data_res_out, 32'd0);
    checkOutput("late_rvalid_stall", 32'(stall_out), 32'd0);
    exp_data = 32'h0;
    @(posedge clk); #1;

    $display("[TB] back-to-back accesses after reset");
    expect_req(32'h600, 4'hF, 32'h0, 1'b0);
    expect_cpl(32'h01020304, 1'b0, 2);
    applyStimulus(mk(OP_L, 3'b010), 32'h600, 32'h0, 0, 1, 32'h01020304, 0);
    expect_req(32'h604, 4'hF, 32'h55AA55AA, 1'b1);
    expect_cpl(exp_data, 1'b0, 1);
    applyStimulus(mk(OP_S, 3'b010), 32'h604, 32'h55AA55AA, 0, -1, 32'h0, 0);
    expect_req(32'h600, 4'b0010, 32'h0, 1'b0);
    expect_cpl(32'h000000FF, 1'b0, 3);
    applyStimulus(mk(OP_L, 3'b100), 32'h601, 32'h0, 1, 2, 32'h0000FF00, 0);

    code_in = NOP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("req_q_left", req_q.size(), 32'd0);
    checkOutput("cpl_q_left", cpl_q.size(), 32'd0);
    checkOutput("mis_q_left", mis_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
